// File: rtl/md5_add_pipe.sv
// md5_add_pipe: pipelined modular adder for the MD5 round datapath.
// Each stage sums one CHUNK-bit slice of x + y plus the carry registered by
// the previous stage. The operand slices that are not yet summed move along
// beside the arithmetic in skew registers, and the sum grows one slice per stage.
// The last stage drives the outputs, so out_* always come from registers.
//
// state | meaning
// ------+---------------------------------------------------------------
// vld_q | per-stage occupancy; a stall freezes every stage, bubbles included
// skew  | high operand slices still waiting for their stage
// sum_q | low sum slices already computed, plus the chunk carry and the tag

module md5_add_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic             in_ci,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  // A zero CHUNK must not reach the divide; the check below rejects it anyway.
  localparam int CW     = (CHUNK > 0) ? CHUNK : 1;
  localparam int STAGES = WIDTH / CW;

  if ((CHUNK < 1) || ((WIDTH % CW) != 0) || (STAGES < 1)) begin : g_param_check
    $error("md5_add_pipe: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic              advance;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_nxt;
  logic              busy_q;

  // The stall is global: one full output register freezes the whole pipe.
  assign advance  = !vld_q[STAGES-1] || out_ready;
  assign in_ready = advance;

  // Next occupancy: shift by one stage on advance, otherwise hold (bubbles too).
  always_comb begin
    vld_nxt = vld_q;
    if (advance) begin
      vld_nxt[0] = in_valid;
      for (int s = 1; s < STAGES; s++) begin
        vld_nxt[s] = vld_q[s-1];
      end
    end
  end

  // Occupancy and busy share one register step, so busy never lags the valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      vld_q  <= vld_nxt;
      busy_q <= |vld_nxt;
    end
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    // RIN: operand bits that have not been summed when the operation enters this stage.
    localparam int RIN = WIDTH - s * CW;
    // LO: sum bits already completed by the earlier stages.
    localparam int LO  = s * CW;

    logic [RIN-1:0]     x_in;
    logic [RIN-1:0]     y_in;
    logic               c_in;
    logic               v_in;
    logic               load;
    logic [TAG_W-1:0]   tag_in;
    logic [CW:0]        part;
    logic [LO+CW-1:0]   sum_nxt;
    logic [LO+CW-1:0]   sum_q;
    logic               co_q;
    logic [TAG_W-1:0]   tag_q;

    if (s == 0) begin : g_head
      assign x_in    = in_x;
      assign y_in    = in_y;
      assign c_in    = in_ci;
      assign v_in    = in_valid;
      assign tag_in  = in_tag;
      assign sum_nxt = part[CW-1:0];
    end else begin : g_body
      assign x_in    = g_stage[s-1].g_skew.x_q;
      assign y_in    = g_stage[s-1].g_skew.y_q;
      assign c_in    = g_stage[s-1].co_q;
      assign v_in    = vld_q[s-1];
      assign tag_in  = g_stage[s-1].tag_q;
      assign sum_nxt = {part[CW-1:0], g_stage[s-1].sum_q};
    end

    // The lowest slice still pending is always at bit 0 of x_in and y_in.
    assign part = {1'b0, x_in[CW-1:0]} + {1'b0, y_in[CW-1:0]} + {{CW{1'b0}}, c_in};

    // Data registers update only when an operation moves in. A bubble entering
    // the stage leaves the previous result visible.
    assign load = advance && v_in;

    // Partial sum, chunk carry and tag advance together with their operation.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q <= '0;
        co_q  <= 1'b0;
        tag_q <= '0;
      end else if (load) begin
        sum_q <= sum_nxt;
        co_q  <= part[CW];
        tag_q <= tag_in;
      end
    end

    if (s < STAGES - 1) begin : g_skew
      logic [RIN-CW-1:0] x_q;
      logic [RIN-CW-1:0] y_q;

      // Operand slices not yet summed move one stage on, with the consumed slice dropped.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_q <= '0;
          y_q <= '0;
        end else if (load) begin
          x_q <= x_in[RIN-1:CW];
          y_q <= y_in[RIN-1:CW];
        end
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign out_sum   = g_stage[STAGES-1].sum_q;
  assign out_co    = g_stage[STAGES-1].co_q;
  assign out_tag   = g_stage[STAGES-1].tag_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_md5_add_pipe.sv
`timescale 1ns/1ps
// Scoreboard bench for md5_add_pipe. There are four instances:
//   inst 0 is (32,8) with out_ready driven by the bench.
//   insts 1..3 are (8,8), (32,4) and (64,16), with out_ready tied high.
// The acceptance monitor pushes expected results. The output monitor pops and compares them.
module tb_md5_add_pipe;

  localparam int NI = 4;
  localparam int W  [NI] = '{32, 8, 32, 64};
  localparam int ST [NI] = '{4, 1, 8, 4};

  typedef struct {
    int          inst;
    logic [63:0] sum;
    logic        co;
    logic [3:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in_x, in_y;
  logic        in_ci;
  logic [3:0]  in_tag;
  logic        out_ready0;
  logic        one = 1'b1;

  logic        rdy0, rdy1, rdy2, rdy3;
  logic        ov0, ov1, ov2, ov3;
  logic [31:0] s0;
  logic [7:0]  s1;
  logic [31:0] s2;
  logic [63:0] s3;
  logic        c0, c1, c2, c3;
  logic [3:0]  t0, t1, t2, t3;
  logic        b0, b1, b2, b3;

  logic        rdy [NI];
  logic        ov  [NI];
  logic        orr [NI];
  logic [63:0] os  [NI];
  logic        oc  [NI];
  logic [3:0]  ot  [NI];
  logic        bz  [NI];

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          hand_v = 0;
  logic [31:0] hand_sum = '0;
  logic        hand_co = 1'b0;
  bit          lat_en = 1;
  bit          bp_done = 0;
  bit          held = 0;
  logic [63:0] held_sum;
  logic        held_co;
  logic [3:0]  held_tag;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  md5_add_pipe #(.WIDTH(32), .CHUNK(8), .TAG_W(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_x(in_x[31:0]), .in_y(in_y[31:0]), .in_ci(in_ci), .in_tag(in_tag),
    .out_valid(ov0), .out_ready(out_ready0), .out_sum(s0), .out_co(c0),
    .out_tag(t0), .busy(b0));

  md5_add_pipe #(.WIDTH(8), .CHUNK(8), .TAG_W(4)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_x(in_x[7:0]), .in_y(in_y[7:0]), .in_ci(in_ci), .in_tag(in_tag),
    .out_valid(ov1), .out_ready(one), .out_sum(s1), .out_co(c1),
    .out_tag(t1), .busy(b1));

  md5_add_pipe #(.WIDTH(32), .CHUNK(4), .TAG_W(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .in_x(in_x[31:0]), .in_y(in_y[31:0]), .in_ci(in_ci), .in_tag(in_tag),
    .out_valid(ov2), .out_ready(one), .out_sum(s2), .out_co(c2),
    .out_tag(t2), .busy(b2));

  md5_add_pipe #(.WIDTH(64), .CHUNK(16), .TAG_W(4)) u_w64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy3),
    .in_x(in_x), .in_y(in_y), .in_ci(in_ci), .in_tag(in_tag),
    .out_valid(ov3), .out_ready(one), .out_sum(s3), .out_co(c3),
    .out_tag(t3), .busy(b3));

  always_comb begin
    rdy[0] = rdy0; rdy[1] = rdy1; rdy[2] = rdy2; rdy[3] = rdy3;
    ov[0]  = ov0;  ov[1]  = ov1;  ov[2]  = ov2;  ov[3]  = ov3;
    orr[0] = out_ready0; orr[1] = one; orr[2] = one; orr[3] = one;
    os[0]  = {32'd0, s0}; os[1] = {56'd0, s1}; os[2] = {32'd0, s2}; os[3] = s3;
    oc[0]  = c0; oc[1] = c1; oc[2] = c2; oc[3] = c3;
    ot[0]  = t0; ot[1] = t1; ot[2] = t2; ot[3] = t3;
    bz[0]  = b0; bz[1] = b1; bz[2] = b2; bz[3] = b3;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic void model(input int w, input logic [63:0] x, input logic [63:0] y,
                                input logic ci, output logic [63:0] s, output logic c);
    logic [64:0] m, f;
    m = (65'd1 << w) - 65'd1;
    f = ({1'b0, x} & m) + ({1'b0, y} & m) + {64'd0, ci};
    s = f[63:0] & m[63:0];
    c = f[w];
  endfunction

  // Output monitor, handshake rule check, stall stability check and acceptance monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (held && ov[0]) begin
        chk("stable_sum", os[0], held_sum);
        chk("stable_co", {63'd0, oc[0]}, {63'd0, held_co});
        chk("stable_tag", {60'd0, ot[0]}, {60'd0, held_tag});
      end
      held     = ov[0] && !orr[0];
      held_sum = os[0];
      held_co  = oc[0];
      held_tag = ot[0];
      for (int k = 0; k < NI; k++) begin
        chk($sformatf("in_ready[%0d]", k), {63'd0, rdy[k]}, {63'd0, (!ov[k] || orr[k])});
        if (ov[k] && orr[k]) begin
          int idx;
          idx = -1;
          foreach (sb[i]) if (idx < 0 && sb[i].inst == k) idx = i;
          if (idx < 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected[%0d]: actual sum %0h with no pending op, required none", k, os[k]);
          end else begin
            exp_t e;
            e = sb[idx];
            sb.delete(idx);
            chk($sformatf("sum[%0d]", k), os[k], e.sum);
            chk($sformatf("co[%0d]", k), {63'd0, oc[k]}, {63'd0, e.co});
            chk($sformatf("tag[%0d]", k), {60'd0, ot[k]}, {60'd0, e.tag});
            if (e.lat) chk($sformatf("latency[%0d]", k), 64'(cyc - e.cyc), 64'(ST[k]));
          end
        end
        if (in_valid && rdy[k]) begin
          exp_t e;
          e.inst = k;
          model(W[k], in_x, in_y, in_ci, e.sum, e.co);
          if (k == 0 && hand_v) begin
            e.sum = {32'd0, hand_sum};
            e.co  = hand_co;
          end
          e.tag = in_tag;
          e.cyc = cyc;
          e.lat = (k != 0) || lat_en;
          sb.push_back(e);
        end
      end
    end
  end

  // Present one operation and hold it until instance 0 accepts it.
  task automatic send(input logic [63:0] x, input logic [63:0] y, input logic ci,
                      input logic [3:0] t, input bit hv, input logic [31:0] hs, input logic hc);
    int n;
    in_valid = 1'b1; in_x = x; in_y = y; in_ci = ci; in_tag = t;
    hand_v = hv; hand_sum = hs; hand_co = hc;
    n = 0;
    @(negedge clk);
    while (!rdy0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: actual in_ready 0 for %0d cycles, required 1", n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    hand_v   = 0;
    in_x     = $urandom;
    in_y     = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: actual %0d pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  logic [31:0] dx  [6] = '{32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'h67452301, 32'h12345678, 32'hFFFFFFFF};
  logic [31:0] dy  [6] = '{32'h00000001, 32'h00000000, 32'h80000000, 32'hEFCDAB89, 32'h11111111, 32'hFFFFFFFF};
  logic        dci [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] ds  [6] = '{32'h00000000, 32'h00000001, 32'h00000000, 32'h5712CE8A, 32'h2345678A, 32'hFFFFFFFF};
  logic        dco [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_ci = 1'b0; in_tag = '0;
    out_ready0 = 1'b1;
    #2;
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("rst_valid[%0d]", k), {63'd0, ov[k]}, 64'd0);
      chk($sformatf("rst_sum[%0d]", k), os[k], 64'd0);
      chk($sformatf("rst_co[%0d]", k), {63'd0, oc[k]}, 64'd0);
      chk($sformatf("rst_tag[%0d]", k), {60'd0, ot[k]}, 64'd0);
      chk($sformatf("rst_busy[%0d]", k), {63'd0, bz[k]}, 64'd0);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, the first one isolated so that its latency is clean.
    send({32'd0, dx[0]}, {32'd0, dy[0]}, dci[0], 4'd3, 1, ds[0], dco[0]);
    idle();
    drain();
    for (int i = 1; i < 6; i++) send({32'd0, dx[i]}, {32'd0, dy[i]}, dci[i], 4'(i), 1, ds[i], dco[i]);
    idle();
    drain();

    // Back-to-back random stream.
    for (int i = 0; i < 100; i++)
      send({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 0, '0, 1'b0);
    idle();
    drain();

    // Backpressure on instance 0.
    lat_en = 0;
    bp_done = 0;
    fork
      begin
        for (int i = 0; i < 10; i++)
          send({32'd0, $urandom}, {32'd0, $urandom}, 1'($urandom_range(0, 1)), 4'(i), 0, '0, 1'b0);
        idle();
        bp_done = 1;
      end
      begin
        while (!bp_done) begin
          @(posedge clk);
          #1 out_ready0 = ($urandom_range(0, 9) >= 4);
        end
      end
    join
    repeat (12) begin
      @(posedge clk);
      #1 out_ready0 = ($urandom_range(0, 9) >= 4);
    end
    out_ready0 = 1'b1;
    drain();
    lat_en = 1;

    // Reset in the middle of operation.
    for (int i = 0; i < 5; i++) send({32'd0, $urandom}, {32'd0, $urandom}, 1'b0, 4'(i), 0, '0, 1'b0);
    idle();
    #1;
    chk("pre_rst_busy", {63'd0, b0}, 64'd1);
    chk("pre_rst_valid", {63'd0, ov0}, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, ov0}, 64'd0);
    chk("mid_rst_busy", {63'd0, b0}, 64'd0);
    chk("mid_rst_sum", {32'd0, s0}, 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_busy", {63'd0, b0}, 64'd0);
    send(64'd1, 64'd2, 1'b0, 4'd5, 1, 32'h00000003, 1'b0);
    idle();
    drain();
    chk("final_busy", {63'd0, b0}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual time %0t, required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
